// File: rtl/bus_capture_port_pkg.sv
// Shared definitions for the processor output bus and its capture port.
//
// BUS_WIDTH is the width of the processor's shared tristate output bus. The
// processor and every block that listens to that bus take their data width
// from here, so the two ends cannot drift apart.
package bus_capture_port_pkg;

    localparam int BUS_WIDTH = 16;

    localparam int CAPTURE_DEPTH = 4;

    localparam int DROP_CNT_WIDTH = 8;

endpackage : bus_capture_port_pkg

// File: rtl/bus_capture_port_sync_fifo.sv
// Synchronous fall-through FIFO used by the bus capture port.
//
// Ports:
//   clock    system clock, rising edge
//   resetn   asynchronous active-low reset (pointers and level only)
//   push     write wr_data at the tail this cycle (caller guarantees room)
//   pop      remove the head entry this cycle (caller guarantees non-empty)
//   wr_data  word to write
//   rd_data  head entry, valid whenever level != 0
//   level    current occupancy, 0..DEPTH
//   empty    level == 0
//   full     level == DEPTH
//
// Full/empty come from the occupancy counter rather than pointer equality,
// so the pointers can be plain modulo-DEPTH counters with no extra wrap bit.
module sync_fifo
    import bus_capture_port_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_WIDTH,
    parameter int DEPTH      = CAPTURE_DEPTH
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage array. Deliberately not reset: the head word is only looked
    // at while level is non-zero, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally because DEPTH is a
    // power of two; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));

endmodule : sync_fifo

// File: rtl/bus_capture_port.sv
// Receive-side capture port for the processor's shared output bus.
//
// Every cycle the processor asserts its bus output enable, the word on the
// bus is written into a small fall-through FIFO that a downstream consumer
// drains with a valid/ready handshake. Words arriving while the FIFO is full
// (and not being popped in the same cycle) are lost; that is recorded by a
// sticky overflow flag and a saturating drop counter.
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   bus_in      processor bus value, only meaningful when bus_valid=1
//   bus_valid   processor bus output enable
//   clear       synchronous clear of overflow and drop_count
//   out_data    FIFO head word, 0 when empty
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word this cycle
//   level       current occupancy, 0..DEPTH
//   overflow    sticky flag, set on any dropped word
//   drop_count  number of dropped words, saturating at all-ones
module bus_capture_port
    import bus_capture_port_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_WIDTH,
    parameter int DEPTH      = CAPTURE_DEPTH,
    parameter int CNT_WIDTH  = DROP_CNT_WIDTH
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [DATA_WIDTH-1:0]      bus_in,
    input  logic                       bus_valid,
    input  logic                       clear,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_count
);

    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] head_data;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .wr_data (bus_in),
        .rd_data (head_data),
        .level   (level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Push qualification. A full FIFO can still accept a word when the
    // consumer frees the head slot in the same cycle; otherwise the word
    // is dropped without touching the memory.
    always_comb begin
        pop  = !fifo_empty && out_ready;
        push = bus_valid && (!fifo_full || pop);
        drop = bus_valid && fifo_full && !pop;
    end

    // Overflow bookkeeping. A drop in the same cycle as clear is counted
    // after the clear, so the consumer never loses evidence of a drop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= drop;
            drop_count <= CNT_WIDTH'(drop);
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end
    end

    // The head entry is masked while empty so the un-reset memory never
    // shows through on out_data.
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : head_data;
    end

endmodule : bus_capture_port

// File: doc/bus_capture_port.md
Name: bus_capture_port

Overview:
- Receive-side peer of the processor's shared 16-bit tristate output bus.
- When the processor drives a register onto `bus`, it also asserts its bus output enable. This block samples `bus` on those cycles and stores each word in a small FIFO.
- A downstream consumer (display/UART/testbench sink) drains the FIFO through a valid/ready handshake.
- Lost words are flagged by a sticky overflow bit and counted by a saturating drop counter.

Parameters:
- DATA_WIDTH, 16, bus/word width; must equal the processor bus width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_WIDTH, 8, width of the drop counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- bus_in  in  DATA_WIDTH  processor bus value; only meaningful when bus_valid=1.
- bus_valid  in  1  processor bus output enable; 1 = bus_in is driven this cycle.
- clear  in  1  synchronous clear of overflow and drop_count.
- out_data  out  DATA_WIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set on any dropped bus word.
- drop_count  out  CNT_WIDTH  dropped words, saturating at all-ones.

Behaviour:
- Reset (resetn=0, asynchronous, any time): read/write pointers=0, level=0, out_valid=0, out_data=0, overflow=0, drop_count=0. The FIFO memory is not reset. Any in-flight capture is discarded.
- Fall-through FIFO, first-word latency 1 cycle:
  - A word captured at edge N appears on out_data with out_valid=1 immediately after edge N.
  - out_valid = (level != 0).
  - out_data is the head entry when out_valid=1, and is forced to 0 when empty.
- pop = out_valid & out_ready. The head advances at the edge; out_data shows the next entry, or 0 if the FIFO is now empty.
- push_req = bus_valid.
- push is accepted when level<DEPTH, or when level==DEPTH and pop occurs in the same cycle (simultaneous push and pop at full is legal).
- Simultaneous push and pop at any level: level unchanged, both pointers advance.
- Simultaneous push and pop at empty: not possible, because pop requires out_valid. The word is captured and level becomes 1.
- Drop: push_req while level==DEPTH and no pop.
  - bus_in is discarded and memory is untouched.
  - overflow<=1.
  - drop_count<=drop_count+1, saturating at 2^CNT_WIDTH-1 (never wraps).
- clear=1: overflow<=0 and drop_count<=0. clear has no effect on FIFO contents or level.
- clear together with a drop in the same cycle: overflow<=1, drop_count<=1 (the drop is counted after the clear).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided from level, not from pointer equality.
- bus_in is ignored whenever bus_valid=0, including X/Z values; no state changes.
- No combinational path from bus_in/bus_valid to any output. out_ready affects only next-state values.
- Holding out_ready=1 permanently with one push per cycle sustains a throughput of one word per cycle with level ≤1.

Decomposition:
- Shared package: BUS_WIDTH=16 constant, used by both processor and this block as the DATA_WIDTH default.
- One natural sub-module: sync_fifo. It holds the memory, pointers, level, and push/pop/full/empty logic, parameterised by DATA_WIDTH and DEPTH.
- The top level adds push qualification, drop detection, the overflow/drop_count logic, and out_data masking.

Test Plan:
- Reset then idle: resetn low for 2 cycles then released, bus_valid=0 -> out_valid=0, out_data=0, level=0, overflow=0, drop_count=0.
- Single capture: bus_in=16'h00A5, bus_valid=1 for one cycle, out_ready=0 -> after the edge out_valid=1, out_data=16'h00A5, level=1. Pulse out_ready for one cycle -> level=0, out_data=0.
- Fill and overflow (DEPTH=4): push 0x0001..0x0006 on consecutive cycles, out_ready=0 -> level=4, drop_count=2, overflow=1. Drain returns 0x0001, 0x0002, 0x0003, 0x0004 in order.
- Full with simultaneous pop: level=4 holding 0x10..0x13, push 0x14 with out_ready=1 in the same cycle -> no drop, level=4, drain yields 0x11, 0x12, 0x13, 0x14.
- Saturation and clear (CNT_WIDTH=2): FIFO full, 5 drops -> drop_count=3. Then clear coincident with a 6th drop -> drop_count=1, overflow=1. Then clear alone -> drop_count=0, overflow=0.
- Reset mid-operation: level=3, assert resetn=0 between clock edges -> outputs go to reset values immediately, without waiting for a clock edge. After release, the next capture of 16'hBEEF appears as the only entry.
